// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: memory-size encodings, default widths and the
// control bundle carried from EX through MEM to WB.
package pipe_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned REG_W_DEF  = 5;

  localparam logic [1:0] MSZ_WORD = 2'b00;
  localparam logic [1:0] MSZ_HALF = 2'b01;
  localparam logic [1:0] MSZ_BYTE = 2'b10;
  localparam logic [1:0] MSZ_RSVD = 2'b11;

  typedef struct packed {
    logic       reg_write;
    logic       memto_reg;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_size;
  } ctrl_t;

  // Legalise the incoming control bundle: bubbles carry no control, $zero is
  // never written, load wins over store, and the reserved size becomes a word.
  function automatic ctrl_t sanitize_ctrl(input logic       valid,
                                          input logic       reg_write,
                                          input logic       memto_reg,
                                          input logic       mem_read,
                                          input logic       mem_write,
                                          input logic [1:0] mem_size,
                                          input logic       wr_zero);
    ctrl_t c;
    c = '0;
    if (valid) begin
      c.reg_write = reg_write & ~wr_zero;
      c.memto_reg = memto_reg;
      c.mem_read  = mem_read;
      c.mem_write = mem_write & ~mem_read;
      c.mem_size  = (mem_size == MSZ_RSVD) ? MSZ_WORD : mem_size;
    end
    return c;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear overrides increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         Clr,
  input  logic         Inc,
  output logic [W-1:0] Count
);

  logic [W-1:0] count_d;

  always_comb begin
    count_d = Count;
    if (Clr) begin
      count_d = '0;
    end else if (Inc && (Count != {W{1'b1}})) begin
      count_d = Count + 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Count <= '0;
    end else begin
      Count <= count_d;
    end
  end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with stall/flush, forwarding and load-hazard taps,
// and saturating debug counters for stall and flush events.
module ex_mem_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned REG_W  = REG_W_DEF,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              CntClr,
  input  logic              Valid_in,
  input  logic              RegWrite_in,
  input  logic              MemtoReg_in,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic [1:0]        MemSize_in,
  input  logic [DATA_W-1:0] ALUResult_in,
  input  logic [DATA_W-1:0] StoreData_in,
  input  logic [REG_W-1:0]  WriteReg_in,
  output logic              Valid_out,
  output logic              RegWrite_out,
  output logic              MemtoReg_out,
  output logic              MemRead_out,
  output logic              MemWrite_out,
  output logic [1:0]        MemSize_out,
  output logic [DATA_W-1:0] ALUResult_out,
  output logic [DATA_W-1:0] StoreData_out,
  output logic [REG_W-1:0]  WriteReg_out,
  output logic              FwdEn,
  output logic [REG_W-1:0]  FwdReg,
  output logic [DATA_W-1:0] FwdData,
  output logic              LoadPending,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  FlushCnt
);

  logic              valid_q;
  ctrl_t             ctrl_q;
  ctrl_t             ctrl_d;
  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] store_q;
  logic [REG_W-1:0]  wreg_q;
  logic              stall_eff;

  always_comb begin
    ctrl_d = sanitize_ctrl(Valid_in, RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in,
                           MemSize_in, (WriteReg_in == '0));
  end

  // Flush beats stall; stall freezes every field including valid.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      alu_q   <= '0;
      store_q <= '0;
      wreg_q  <= '0;
    end else if (Flush) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      alu_q   <= '0;
      store_q <= '0;
      wreg_q  <= '0;
    end else if (!Stall) begin
      valid_q <= Valid_in;
      ctrl_q  <= ctrl_d;
      alu_q   <= ALUResult_in;
      store_q <= StoreData_in;
      wreg_q  <= WriteReg_in;
    end
  end

  assign Valid_out     = valid_q;
  assign RegWrite_out  = ctrl_q.reg_write;
  assign MemtoReg_out  = ctrl_q.memto_reg;
  assign MemRead_out   = ctrl_q.mem_read;
  assign MemWrite_out  = ctrl_q.mem_write;
  assign MemSize_out   = ctrl_q.mem_size;
  assign ALUResult_out = alu_q;
  assign StoreData_out = store_q;
  assign WriteReg_out  = wreg_q;

  // Loads cannot forward from here; their data only exists after MEM.
  assign FwdEn       = valid_q & ctrl_q.reg_write & ~ctrl_q.memto_reg;
  assign FwdReg      = wreg_q;
  assign FwdData     = alu_q;
  assign LoadPending = valid_q & ctrl_q.mem_read & ctrl_q.reg_write;

  assign stall_eff = Stall & ~Flush;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .Clk  (Clk),
    .Rst  (Rst),
    .Clr  (CntClr),
    .Inc  (stall_eff),
    .Count(StallCnt)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_flush_cnt (
    .Clk  (Clk),
    .Rst  (Rst),
    .Clr  (CntClr),
    .Inc  (Flush),
    .Count(FlushCnt)
  );

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed-vector bench for ex_mem_reg: expected responses are queued per
// edge and popped by an independent monitor on the falling edge.
module tb_ex_mem_reg;

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned CW = 4;

  logic          Clk, Rst, Stall, Flush, CntClr;
  logic          Valid_in, RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in;
  logic [1:0]    MemSize_in;
  logic [DW-1:0] ALUResult_in, StoreData_in;
  logic [RW-1:0] WriteReg_in;
  logic          Valid_out, RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out;
  logic [1:0]    MemSize_out;
  logic [DW-1:0] ALUResult_out, StoreData_out, FwdData;
  logic [RW-1:0] WriteReg_out, FwdReg;
  logic          FwdEn, LoadPending;
  logic [CW-1:0] StallCnt, FlushCnt;

  ex_mem_reg #(
    .DATA_W(DW),
    .REG_W (RW),
    .CNT_W (CW)
  ) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .Stall        (Stall),
    .Flush        (Flush),
    .CntClr       (CntClr),
    .Valid_in     (Valid_in),
    .RegWrite_in  (RegWrite_in),
    .MemtoReg_in  (MemtoReg_in),
    .MemRead_in   (MemRead_in),
    .MemWrite_in  (MemWrite_in),
    .MemSize_in   (MemSize_in),
    .ALUResult_in (ALUResult_in),
    .StoreData_in (StoreData_in),
    .WriteReg_in  (WriteReg_in),
    .Valid_out    (Valid_out),
    .RegWrite_out (RegWrite_out),
    .MemtoReg_out (MemtoReg_out),
    .MemRead_out  (MemRead_out),
    .MemWrite_out (MemWrite_out),
    .MemSize_out  (MemSize_out),
    .ALUResult_out(ALUResult_out),
    .StoreData_out(StoreData_out),
    .WriteReg_out (WriteReg_out),
    .FwdEn        (FwdEn),
    .FwdReg       (FwdReg),
    .FwdData      (FwdData),
    .LoadPending  (LoadPending),
    .StallCnt     (StallCnt),
    .FlushCnt     (FlushCnt)
  );

  typedef struct {
    logic v, rw, mtr, mr, mw;
    logic [1:0] msz;
    logic [31:0] alu, sd;
    logic [4:0] wr;
    logic st, fl, cl;
  } in_t;

  // ctl packs {RegWrite, MemtoReg, MemRead, MemWrite}
  typedef struct {
    logic v;
    logic [3:0] ctl;
    logic [1:0] msz;
    logic [31:0] alu, sd;
    logic [4:0] wr;
    logic fe, lp;
    int sc, fc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   passed = 0;
  int   total  = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic in_t vin(logic v, logic rw, logic mtr, logic mr, logic mw,
                              logic [1:0] msz, logic [31:0] alu, logic [31:0] sd,
                              logic [4:0] wr, logic st, logic fl, logic cl);
    in_t i;
    i.v = v; i.rw = rw; i.mtr = mtr; i.mr = mr; i.mw = mw; i.msz = msz;
    i.alu = alu; i.sd = sd; i.wr = wr; i.st = st; i.fl = fl; i.cl = cl;
    return i;
  endfunction

  function automatic exp_t vexp(logic v, logic [3:0] ctl, logic [1:0] msz, logic [31:0] alu,
                                logic [31:0] sd, logic [4:0] wr, logic fe, logic lp,
                                int sc, int fc);
    exp_t e;
    e.v = v; e.ctl = ctl; e.msz = msz; e.alu = alu; e.sd = sd; e.wr = wr;
    e.fe = fe; e.lp = lp; e.sc = sc; e.fc = fc;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 32'(Valid_out), 0);
    check({tag, "_ctl"}, 32'({RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out}), 0);
    check({tag, "_msz"}, 32'(MemSize_out), 0);
    check({tag, "_alu"}, ALUResult_out, 0);
    check({tag, "_sd"}, StoreData_out, 0);
    check({tag, "_wr"}, 32'(WriteReg_out), 0);
    check({tag, "_fwd_en"}, 32'(FwdEn), 0);
    check({tag, "_ld_pend"}, 32'(LoadPending), 0);
    check({tag, "_stall_cnt"}, 32'(StallCnt), 0);
    check({tag, "_flush_cnt"}, 32'(FlushCnt), 0);
  endtask

  task automatic drive(input in_t i);
    Valid_in = i.v; RegWrite_in = i.rw; MemtoReg_in = i.mtr; MemRead_in = i.mr;
    MemWrite_in = i.mw; MemSize_in = i.msz; ALUResult_in = i.alu; StoreData_in = i.sd;
    WriteReg_in = i.wr; Stall = i.st; Flush = i.fl; CntClr = i.cl;
  endtask

  task automatic step(input in_t i, input exp_t e);
    drive(i);
    @(posedge Clk);
    q.push_back(e);
    #1;
  endtask

  always @(negedge Clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      check("valid", 32'(Valid_out), 32'(mon_e.v));
      check("ctl", 32'({RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out}),
            32'(mon_e.ctl));
      check("msz", 32'(MemSize_out), 32'(mon_e.msz));
      check("alu", ALUResult_out, mon_e.alu);
      check("store_data", StoreData_out, mon_e.sd);
      check("write_reg", 32'(WriteReg_out), 32'(mon_e.wr));
      check("fwd_en", 32'(FwdEn), 32'(mon_e.fe));
      check("fwd_reg", 32'(FwdReg), 32'(mon_e.wr));
      check("fwd_data", FwdData, mon_e.alu);
      check("load_pending", 32'(LoadPending), 32'(mon_e.lp));
      check("stall_cnt", 32'(StallCnt), 32'(mon_e.sc));
      check("flush_cnt", 32'(FlushCnt), 32'(mon_e.fc));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    Rst = 1'b1;
    drive(vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #3;
    check_zero("rst_init");
    @(posedge Clk);
    @(posedge Clk);
    #1 Rst = 1'b0;

    // Build up nonzero state and counters before the asynchronous reset
    step(vin(1, 1, 0, 0, 0, 2'b00, 'h1234, 0, 1, 0, 0, 0),
         vexp(1, 4'b1000, 0, 'h1234, 0, 1, 1, 0, 0, 0));
    step(vin(1, 0, 1, 1, 0, 2'b01, 'h9999, 'h8888, 6, 1, 0, 0),
         vexp(1, 4'b1000, 0, 'h1234, 0, 1, 1, 0, 1, 0));
    step(vin(1, 1, 0, 0, 0, 2'b00, 'h55, 'h66, 7, 0, 1, 0),
         vexp(0, 4'b0000, 0, 0, 0, 0, 0, 0, 1, 1));
    step(vin(1, 0, 0, 0, 1, 2'b10, 'h40, 'hdead, 0, 0, 0, 0),
         vexp(1, 4'b0001, 2'b10, 'h40, 'hdead, 0, 0, 0, 1, 1));

    @(negedge Clk);
    #2;
    drive(vin(1, 1, 1, 1, 1, 2'b11, 'hff, 'hee, 7, 1, 1, 1));
    Rst = 1'b1;
    #1;
    check_zero("rst_async");
    @(posedge Clk);
    #1;
    check_zero("rst_hold");
    Rst = 1'b0;

    step(vin(1, 1, 0, 0, 0, 2'b00, 'h1234, 0, 2, 0, 0, 0),
         vexp(1, 4'b1000, 0, 'h1234, 0, 2, 1, 0, 0, 0));

    // Stall hold of instr A while B waits
    step(vin(1, 1, 0, 0, 0, 2'b00, 'hA0, 'h11, 8, 0, 0, 0),
         vexp(1, 4'b1000, 0, 'hA0, 'h11, 8, 1, 0, 0, 0));
    for (int k = 1; k <= 3; k++) begin
      step(vin(1, 1, 1, 1, 0, 2'b01, 'hB0, 'h22, 9, 1, 0, 0),
           vexp(1, 4'b1000, 0, 'hA0, 'h11, 8, 1, 0, k, 0));
    end

    // Flush with stall, valid store in EX
    step(vin(1, 0, 0, 0, 1, 2'b00, 'h100, 'h55, 0, 1, 1, 0),
         vexp(0, 4'b0000, 0, 0, 0, 0, 0, 0, 3, 1));
    // $zero destination
    step(vin(1, 1, 0, 0, 0, 2'b00, 'h7, 0, 0, 0, 0, 0),
         vexp(1, 4'b0000, 0, 'h7, 0, 0, 0, 0, 3, 1));
    // Invalid instruction: control gated, data kept
    step(vin(0, 1, 0, 0, 1, 2'b10, 'h8, 'h9, 5, 0, 0, 0),
         vexp(0, 4'b0000, 0, 'h8, 'h9, 5, 0, 0, 3, 1));
    // Load to $9, then ALU op to $9
    step(vin(1, 1, 1, 1, 0, 2'b01, 'h200, 0, 9, 0, 0, 0),
         vexp(1, 4'b1110, 2'b01, 'h200, 0, 9, 0, 1, 3, 1));
    step(vin(1, 1, 0, 0, 0, 2'b00, 'h300, 0, 9, 0, 0, 0),
         vexp(1, 4'b1000, 0, 'h300, 0, 9, 1, 0, 3, 1));
    // Load+store together, reserved size
    step(vin(1, 1, 1, 1, 1, 2'b11, 'h44, 'h66, 4, 0, 0, 0),
         vexp(1, 4'b1110, 2'b00, 'h44, 'h66, 4, 0, 1, 3, 1));

    // Saturation of the 4-bit stall counter
    for (int k = 1; k <= 20; k++) begin
      step(vin(1, 0, 0, 0, 1, 2'b10, 'h77, 'h88, 6, 1, 0, 0),
           vexp(1, 4'b1110, 0, 'h44, 'h66, 4, 0, 1, (3 + k > 15) ? 15 : 3 + k, 1));
    end
    step(vin(1, 0, 0, 0, 1, 2'b10, 'h77, 'h88, 6, 1, 0, 1),
         vexp(1, 4'b1110, 0, 'h44, 'h66, 4, 0, 1, 0, 0));
    step(vin(1, 0, 0, 0, 1, 2'b10, 'h77, 'h88, 6, 1, 0, 0),
         vexp(1, 4'b1110, 0, 'h44, 'h66, 4, 0, 1, 1, 0));
    step(vin(1, 0, 0, 0, 1, 2'b10, 'h77, 'h88, 6, 0, 1, 1),
         vexp(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0));
    step(vin(1, 1, 0, 0, 0, 2'b10, 'h5, 'h6, 3, 0, 0, 0),
         vexp(1, 4'b1000, 2'b10, 'h5, 'h6, 3, 1, 0, 0, 0));

    @(negedge Clk);
    #1;
    check("queue_drained", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
